align_ctrl64: RTL and testbench
===============================

# align_ctrl64

Sequencing controller for the 64-bit exponent-alignment stage (Normalise64) of the double-precision add/sub datapath. Accepts an operand-exponent pair over a valid/ready handshake, drives the aligner's load/enable for exactly the required shift count, and checks the aligner's OE flag. It bypasses shifting when the exponent gap flushes the smaller mantissa, then presents a result token with status to the adder stage.

## Interface
- MANT_W, 53: aligned mantissa width; exponent gaps ≥ MANT_W take the flush path.
- EXP_W, 11: exponent width.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset; clears all state when 0.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  controller can accept; high only in IDLE.
- in_ea, in_eb  in  EXP_W  biased exponents of A and B.
- aln_load  out  1  aligner load strobe.
- aln_en  out  1  aligner enable.
- aln_oe  in  1  aligner "exponents equal" flag (registered inside the aligner).
- out_valid  out  1  alignment complete; high only in DONE.
- out_ready  in  1  downstream accepts the token.
- out_swap  out  1  1 when in_eb > in_ea, so B carries the result exponent.
- out_flush  out  1  1 when the gap ≥ MANT_W; the smaller operand is treated as zero.
- out_err  out  1  1 when aln_oe was 0 at CHECK.
- out_cycles  out  8  cycles from accept to first out_valid, saturating at 255.

## Operation
- States: IDLE, LOAD, SHIFT, SETTLE, CHECK, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch diff=|in_ea−in_eb| (unsigned, EXP_W bits), swap=(in_eb>in_ea), and flush=(diff ≥ MANT_W); go to LOAD.
- LOAD:
  - aln_load=1, aln_en=1 for one cycle.
  - Next state: flush → DONE; diff=0 → SETTLE; else → SHIFT with cnt=diff.
- SHIFT:
  - aln_en=1, cnt decrements each cycle.
  - Go to SETTLE on the cycle cnt=1.
  - Total SHIFT cycles = diff.
- SETTLE: aln_en=1 for one cycle, so the aligner registers OE=1.
- CHECK: aln_en=0; sample aln_oe and set err=~aln_oe; go to DONE.
- DONE:
  - out_valid=1; out_swap, out_flush, out_err, and out_cycles are stable.
  - On out_ready, go to IDLE.
- aln_load and aln_en are 0 in IDLE, CHECK, and DONE. aln_load=1 only in LOAD.
- On the flush path, aln_en is not raised after LOAD, so the aligner holds its loaded values and out_err=0.
- out_cycles counts every cycle from the acceptance edge until out_valid first rises. It saturates and does not wrap.
- in_valid is ignored outside IDLE. There is no abort; only rst=0 cancels an operation.

## Timing
- Cycle n denotes the cycle following the n-th rising edge after the accepting edge.
- Normal path: LOAD = cycle 1; SHIFT = cycles 2..1+diff; SETTLE = cycle 2+diff; CHECK = cycle 3+diff; out_valid first high in cycle 4+diff. out_cycles = 4+diff.
- diff=0: LOAD, SETTLE, CHECK; out_valid in cycle 4; out_cycles=4.
- Flush path: out_valid in cycle 2; out_cycles=2.
- Maximum normal-path latency is 4+52=56 cycles.
- out_valid with out_ready=0: the token and its fields hold indefinitely.
- out_valid and out_ready both high: the next cycle is IDLE with in_ready=1. There is no same-cycle re-accept.
- Reset values (any time rst=0, including mid-SHIFT): state=IDLE, in_ready=1, and all of the following are 0: out_valid, aln_load, aln_en, out_swap, out_flush, out_err, out_cycles, cnt.
- After rst deasserts, the first edge may accept.

## Test plan
- in_ea=1030, in_eb=1027 → LOAD, 3 SHIFT, SETTLE, CHECK; out_valid in cycle 7; out_swap=0, out_flush=0, out_err=0, out_cycles=7; aln_en high for exactly 5 cycles.
- in_ea=in_eb=1023 → out_valid in cycle 4; out_cycles=4; aln_en high for 2 cycles.
- in_ea=1000, in_eb=1100 (diff=100) → flush path; out_valid in cycle 2; out_flush=1, out_swap=1; aln_en high in LOAD only.
- Diff=52 vs 53: 52 → 52 SHIFT cycles, out_cycles=56, out_flush=0; 53 → flush, out_cycles=2.
- aln_oe stubbed to 0 with diff=2 → out_err=1 in DONE. Hold out_ready=0 for 10 cycles: all outputs stable, in_ready=0, and a new in_valid is ignored.
- Pull rst low in cycle 3 of a diff=20 operation → asynchronously IDLE, all outputs at reset values. A new request after release completes normally.

Source files
------------

// File: rtl/align_ctrl64.sv
// Purpose : sequencing controller for the 64-bit exponent-alignment stage; drives aligner load/enable and checks its OE flag.
// Latency : accept -> out_valid in 4+diff cycles (diff = |ea-eb|), or 2 cycles when the gap flushes the smaller mantissa.
// Backpr. : in_ready only in IDLE; the DONE token and its status fields hold until out_ready, no same-cycle re-accept.
//
// Ports:
//   clk, rst (async active-low)            clock and reset
//   in_valid/in_ready, in_ea, in_eb        operand-exponent pair handshake
//   aln_load, aln_en, aln_oe               aligner control and its registered "exponents equal" flag
//   out_valid/out_ready                    result token handshake
//   out_swap, out_flush, out_err           status of the completed alignment
//   out_cycles                             accept-to-out_valid cycle count, saturating at 255
module align_ctrl64 #(
    parameter int MANT_W = 53,
    parameter int EXP_W  = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [EXP_W-1:0] in_ea,
    input  logic [EXP_W-1:0] in_eb,
    output logic             aln_load,
    output logic             aln_en,
    input  logic             aln_oe,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_swap,
    output logic             out_flush,
    output logic             out_err,
    output logic [7:0]       out_cycles
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SHIFT  = 3'd2,
        SETTLE = 3'd3,
        CHECK  = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam logic [EXP_W-1:0] FLUSH_GAP = EXP_W'(MANT_W);
    localparam logic [EXP_W-1:0] ONE       = EXP_W'(1);

    state_t           state, state_nxt;
    logic [EXP_W-1:0] diff;
    logic [EXP_W-1:0] cnt;
    logic [EXP_W-1:0] diff_in;
    logic             swap_in;
    logic             accept;

    assign swap_in = (in_eb > in_ea);
    assign diff_in = swap_in ? (in_eb - in_ea) : (in_ea - in_eb);
    assign accept  = (state == IDLE) && in_valid;

    // Next-state and Moore outputs
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        aln_load  = 1'b0;
        aln_en    = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = LOAD;
            end
            LOAD: begin
                aln_load = 1'b1;
                aln_en   = 1'b1;
                if (out_flush)         state_nxt = DONE;
                else if (diff == '0)   state_nxt = SETTLE;
                else                   state_nxt = SHIFT;
            end
            SHIFT: begin
                aln_en = 1'b1;
                if (cnt == ONE) state_nxt = SETTLE;
            end
            SETTLE: begin
                // one extra enable so the aligner registers its OE flag
                aln_en    = 1'b1;
                state_nxt = CHECK;
            end
            CHECK: begin
                state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            diff       <= '0;
            cnt        <= '0;
            out_swap   <= 1'b0;
            out_flush  <= 1'b0;
            out_err    <= 1'b0;
            out_cycles <= 8'd0;
        end else begin
            state <= state_nxt;

            if (accept) begin
                diff       <= diff_in;
                out_swap   <= swap_in;
                out_flush  <= (diff_in >= FLUSH_GAP);
                out_err    <= 1'b0;
                // the accepting edge itself starts cycle 1
                out_cycles <= 8'd1;
            end

            // counter runs until DONE is entered, so DONE shows its own cycle number
            if (state != IDLE && state != DONE) begin
                if (out_cycles != 8'hFF) out_cycles <= out_cycles + 8'd1;
            end

            if (state == LOAD && !out_flush && diff != '0) cnt <= diff;
            if (state == SHIFT) cnt <= cnt - ONE;

            if (state == CHECK) out_err <= ~aln_oe;
        end
    end

endmodule

// File: tb/tb_align_ctrl64.sv
module tb_align_ctrl64;

    localparam int MANT_W = 53;
    localparam int EXP_W  = 11;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [EXP_W-1:0] in_ea, in_eb;
    logic             aln_load, aln_en, aln_oe;
    logic             out_valid, out_ready;
    logic             out_swap, out_flush, out_err;
    logic [7:0]       out_cycles;

    int errors = 0;
    int checks = 0;

    align_ctrl64 #(.MANT_W(MANT_W), .EXP_W(EXP_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ea(in_ea), .in_eb(in_eb),
        .aln_load(aln_load), .aln_en(aln_en), .aln_oe(aln_oe),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_swap(out_swap), .out_flush(out_flush), .out_err(out_err),
        .out_cycles(out_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " in_ready"},   int'(in_ready), 1);
        check({tag, " out_valid"},  int'(out_valid), 0);
        check({tag, " aln_load"},   int'(aln_load), 0);
        check({tag, " aln_en"},     int'(aln_en), 0);
        check({tag, " out_swap"},   int'(out_swap), 0);
        check({tag, " out_flush"},  int'(out_flush), 0);
        check({tag, " out_err"},    int'(out_err), 0);
        check({tag, " out_cycles"}, int'(out_cycles), 0);
    endtask

    typedef struct {
        int ea;
        int eb;
        bit oe;
        int hold;
        int exp_lat;
        bit exp_swap;
        bit exp_flush;
        bit exp_err;
        int exp_en;
    } vec_t;

    // Reference: derived from the exponent gap alone.
    function automatic vec_t model(input int ea, input int eb, input bit oe, input int hold);
        vec_t v;
        int d;
        d = (ea > eb) ? ea - eb : eb - ea;
        v.ea = ea; v.eb = eb; v.oe = oe; v.hold = hold;
        v.exp_swap  = (eb > ea);
        v.exp_flush = (d >= MANT_W);
        v.exp_lat   = v.exp_flush ? 2 : ((4 + d > 255) ? 255 : 4 + d);
        v.exp_err   = v.exp_flush ? 1'b0 : ~oe;
        v.exp_en    = v.exp_flush ? 1 : d + 2;
        return v;
    endfunction

    // Runs one operation; cycle numbers are counted from the accepting edge.
    task automatic run_op(input vec_t v, input string tag);
        int cyc;
        int en_cnt;
        int load_cnt;
        bit seen;
        bit s_swap, s_flush, s_err;
        logic [7:0] s_cyc;
        @(negedge clk);
        aln_oe    = v.oe;
        in_ea     = EXP_W'(v.ea);
        in_eb     = EXP_W'(v.eb);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        check({tag, " in_ready before accept"}, int'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 1; en_cnt = 0; load_cnt = 0; seen = 1'b0;
        while (cyc < 300) begin
            if (aln_en) en_cnt++;
            if (aln_load) load_cnt++;
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
            if (in_ready) begin
                check({tag, " in_ready busy"}, int'(in_ready), 0);
                break;
            end
            @(negedge clk);
            cyc++;
        end
        check({tag, " out_valid seen"}, int'(seen), 1);
        if (seen) begin
            check({tag, " latency"},    cyc, v.exp_lat);
            check({tag, " out_cycles"}, int'(out_cycles), v.exp_lat);
            check({tag, " out_swap"},   int'(out_swap), int'(v.exp_swap));
            check({tag, " out_flush"},  int'(out_flush), int'(v.exp_flush));
            check({tag, " out_err"},    int'(out_err), int'(v.exp_err));
            check({tag, " aln_en cycles"}, en_cnt, v.exp_en);
            check({tag, " aln_load cycles"}, load_cnt, 1);
            s_swap = out_swap; s_flush = out_flush; s_err = out_err; s_cyc = out_cycles;
            // stall downstream while offering a new request that must be ignored
            for (int i = 0; i < v.hold; i++) begin
                in_valid = 1'b1;
                in_ea = EXP_W'($urandom_range(0, 2047));
                in_eb = EXP_W'($urandom_range(0, 2047));
                @(negedge clk);
                if ({out_valid, in_ready, aln_en, aln_load, out_swap, out_flush, out_err} !=
                    {1'b1, 1'b0, 1'b0, 1'b0, s_swap, s_flush, s_err} || out_cycles != s_cyc) begin
                    check({tag, " hold stable"},
                          int'({out_valid, in_ready, aln_en, out_swap, out_flush, out_err}),
                          int'({1'b1, 1'b0, 1'b0, s_swap, s_flush, s_err}));
                end else begin
                    checks++;
                end
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            check({tag, " idle after release"}, int'({in_ready, out_valid}), 2);
        end
    endtask

    vec_t vecs[7];
    vec_t rv;

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_ea     = '0;
        in_eb     = '0;
        aln_oe    = 1'b1;
        out_ready = 1'b0;

        //            ea    eb    oe hold lat swap flush err en
        vecs[0] = '{1030, 1027, 1'b1, 0,   7, 1'b0, 1'b0, 1'b0,  5};
        vecs[1] = '{1023, 1023, 1'b1, 0,   4, 1'b0, 1'b0, 1'b0,  2};
        vecs[2] = '{1000, 1100, 1'b1, 0,   2, 1'b1, 1'b1, 1'b0,  1};
        vecs[3] = '{1052, 1000, 1'b1, 0,  56, 1'b0, 1'b0, 1'b0, 54};
        vecs[4] = '{1000, 1053, 1'b1, 0,   2, 1'b1, 1'b1, 1'b0,  1};
        vecs[5] = '{ 500,  502, 1'b0, 10,  6, 1'b1, 1'b0, 1'b1,  4};
        vecs[6] = '{2047,    0, 1'b0, 2,   2, 1'b0, 1'b1, 1'b0,  1};

        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) run_op(vecs[i], $sformatf("vec%0d", i));

        // Asynchronous reset in cycle 3 of a diff=20 operation (swap latched so reset must clear it)
        @(negedge clk);
        in_ea = EXP_W'(1000); in_eb = EXP_W'(1020); aln_oe = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid-op aln_en", int'(aln_en), 1);
        #2 rst = 1'b0;
        #1 check_reset_outputs("async reset");
        @(negedge clk);
        check_reset_outputs("held reset");
        rst = 1'b1;
        run_op(model(1000, 1020, 1'b1, 0), "after reset");

        // Randomized operations against the reference model
        for (int n = 0; n < 40; n++) begin
            int ea, eb, gap;
            ea  = $urandom_range(0, 2047);
            gap = $urandom_range(0, 60);
            eb  = $urandom_range(0, 1) ? ea + gap : ea - gap;
            if (eb < 0) eb = 0;
            if (eb > 2047) eb = 2047;
            rv = model(ea, eb, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
            run_op(rv, $sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
